// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback commit block: default queue depth,
// result-bundle field widths, the queued entry layout and a small helper.
package wb_commit_pkg;

  localparam int WB_DEPTH   = 2;
  localparam int WB_IDX_W   = 4;
  localparam int WB_DATA_W  = 32;
  localparam int WB_ENTRY_W = WB_IDX_W + WB_DATA_W;
  localparam int WB_NREGS   = 16;

  // One queued GPR write: {wdst, wdata}, 36 bits.
  typedef struct packed {
    logic [WB_IDX_W-1:0]  wdst;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

  // One-hot register mask for a GPR index.
  function automatic logic [WB_NREGS-1:0] reg_onehot(input logic [WB_IDX_W-1:0] idx);
    reg_onehot = WB_NREGS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue for wb_commit: DEPTH entries of {wdst, wdata}.
// Besides the head it presents every entry ordered by age (slot 0 = oldest)
// with a thermometer valid vector, used for the pending mask and, when
// WB_BYPASS_EN is defined, for the bypass search.
module wb_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WB_IDX_W-1:0]           push_wdst,
  input  logic [WB_DATA_W-1:0]          push_wdata,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [WB_IDX_W-1:0]           head_wdst,
  output logic [WB_DATA_W-1:0]          head_wdata,
  output logic [DEPTH-1:0]              ord_valid,
`ifdef WB_BYPASS_EN
  output logic [DEPTH*WB_DATA_W-1:0]    ord_wdata,
`endif
  output logic [DEPTH*WB_IDX_W-1:0]     ord_wdst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full queue refuses pushes even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_wdst  = mem[rd_ptr].wdst;
  assign head_wdata = mem[rd_ptr].wdata;

  // Entry storage; no reset needed because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{wdst: push_wdst, wdata: push_wdata};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Age-ordered view of the queue contents.
  always_comb begin
    ord_valid = '0;
    ord_wdst  = '0;
`ifdef WB_BYPASS_EN
    ord_wdata = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      ord_valid[k] = (CW'(k) < count);
      ord_wdst[k*WB_IDX_W +: WB_IDX_W] = mem[rd_ptr + PW'(k)].wdst;
`ifdef WB_BYPASS_EN
      ord_wdata[k*WB_DATA_W +: WB_DATA_W] = mem[rd_ptr + PW'(k)].wdata;
`endif
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: consumes execute-unit results, owns SR.T, queues GPR
// writes in order and shares the single register-file write port with LSU
// load returns (LSU always wins). Optional feature macro: WB_BYPASS_EN adds
// a combinational bypass lookup into the queue (youngest match wins).
//
// Handshake: a result transfers on a rising edge where ex_valid && ex_ready.
// ex_ready depends only on registered queue state (!full), never on ex_valid
// or on a same-cycle pop. T-only results transfer but never take a queue slot.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int   DEPTH  = WB_DEPTH,
  parameter logic T_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_t_wen,
  input  logic                  ex_t,
  input  logic                  ex_wen,
  input  logic [WB_IDX_W-1:0]   ex_wdst,
  input  logic [WB_DATA_W-1:0]  ex_wdata,
  input  logic                  sr_t_wr,
  input  logic                  sr_t_wdata,
  output logic                  sr_t,
  input  logic                  lsu_wen,
  input  logic [WB_IDX_W-1:0]   lsu_wdst,
  input  logic [WB_DATA_W-1:0]  lsu_wdata,
  output logic                  rf_wen,
  output logic [WB_IDX_W-1:0]   rf_wdst,
  output logic [WB_DATA_W-1:0]  rf_wdata,
`ifdef WB_BYPASS_EN
  input  logic [WB_IDX_W-1:0]   byp_rsel,
  output logic                  byp_hit,
  output logic [WB_DATA_W-1:0]  byp_data,
`endif
  output logic [WB_NREGS-1:0]   pend_mask
);

  logic                       accept;
  logic                       q_push;
  logic                       q_pop;
  logic                       q_full;
  logic                       q_empty;
  logic                       q_head_valid;
  logic [WB_IDX_W-1:0]        head_wdst;
  logic [WB_DATA_W-1:0]       head_wdata;
  logic [DEPTH-1:0]           ord_valid;
  logic [DEPTH*WB_IDX_W-1:0]  ord_wdst;
`ifdef WB_BYPASS_EN
  logic [DEPTH*WB_DATA_W-1:0] ord_wdata;
`endif

  assign ex_ready = ~q_full;
  assign accept   = ex_valid & ex_ready;
  assign q_push   = accept & ex_wen;
  // While reset is held the queue is being discarded, so it never drives
  // the port; this keeps a reset mid-drain from producing a stray write.
  assign q_head_valid = rst_n & ~q_empty;
  assign q_pop        = q_head_valid & ~lsu_wen;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_wdst  (ex_wdst),
    .push_wdata (ex_wdata),
    .pop        (q_pop),
    .full       (q_full),
    .empty      (q_empty),
    .head_wdst  (head_wdst),
    .head_wdata (head_wdata),
    .ord_valid  (ord_valid),
`ifdef WB_BYPASS_EN
    .ord_wdata  (ord_wdata),
`endif
    .ord_wdst   (ord_wdst)
  );

  // Architectural T: an accepted execute update beats a same-cycle SR write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_t <= T_INIT;
    end else if (accept && ex_t_wen) begin
      sr_t <= ex_t;
    end else if (sr_t_wr) begin
      sr_t <= sr_t_wdata;
    end
  end

  // Register-file port arbitration: LSU first, then the queue head.
  always_comb begin
    rf_wen   = 1'b0;
    rf_wdst  = '0;
    rf_wdata = '0;
    if (lsu_wen) begin
      rf_wen   = 1'b1;
      rf_wdst  = lsu_wdst;
      rf_wdata = lsu_wdata;
    end else if (q_head_valid) begin
      rf_wen   = 1'b1;
      rf_wdst  = head_wdst;
      rf_wdata = head_wdata;
    end
  end

  // Pending-destination mask over all occupied entries.
  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_valid[k]) begin
        pend_mask = pend_mask | reg_onehot(ord_wdst[k*WB_IDX_W +: WB_IDX_W]);
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass search; walking oldest to youngest lets the youngest match win.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && (ord_wdst[k*WB_IDX_W +: WB_IDX_W] == byp_rsel)) begin
        byp_hit  = 1'b1;
        byp_data = ord_wdata[k*WB_DATA_W +: WB_DATA_W];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Testbench for wb_commit: directed vector table, a bypass sequence when
// WB_BYPASS_EN is defined, then randomized traffic against a queue model.
module tb_wb_commit;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ex_valid, ex_ready, ex_t_wen, ex_t, ex_wen;
  logic [3:0]  ex_wdst;
  logic [31:0] ex_wdata;
  logic        sr_t_wr, sr_t_wdata, sr_t;
  logic        lsu_wen;
  logic [3:0]  lsu_wdst;
  logic [31:0] lsu_wdata;
  logic        rf_wen;
  logic [3:0]  rf_wdst;
  logic [31:0] rf_wdata;
  logic [15:0] pend_mask;
`ifdef WB_BYPASS_EN
  logic [3:0]  byp_rsel;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  wb_commit #(.DEPTH(DEPTH), .T_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_t_wen   (ex_t_wen),
    .ex_t       (ex_t),
    .ex_wen     (ex_wen),
    .ex_wdst    (ex_wdst),
    .ex_wdata   (ex_wdata),
    .sr_t_wr    (sr_t_wr),
    .sr_t_wdata (sr_t_wdata),
    .sr_t       (sr_t),
    .lsu_wen    (lsu_wen),
    .lsu_wdst   (lsu_wdst),
    .lsu_wdata  (lsu_wdata),
    .rf_wen     (rf_wen),
    .rf_wdst    (rf_wdst),
    .rf_wdata   (rf_wdata),
`ifdef WB_BYPASS_EN
    .byp_rsel   (byp_rsel),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data),
`endif
    .pend_mask  (pend_mask)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q[$];   // {wdst, wdata}, front = oldest
  logic        m_sr_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst_n = 1'b1; ex_valid = 1'b0; ex_t_wen = 1'b0; ex_t = 1'b0; ex_wen = 1'b0;
    ex_wdst = '0; ex_wdata = '0; sr_t_wr = 1'b0; sr_t_wdata = 1'b0;
    lsu_wen = 1'b0; lsu_wdst = '0; lsu_wdata = '0;
`ifdef WB_BYPASS_EN
    byp_rsel = '0;
`endif
  endtask

  // Model of one rising edge, from the rules for queue, port and T.
  task automatic model_edge();
    bit acc;
    if (!rst_n) begin
      exp_q.delete();
      m_sr_t = 1'b0;
    end else begin
      acc = ex_valid && (exp_q.size() < DEPTH);
      if (!lsu_wen && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc && ex_wen) exp_q.push_back({ex_wdst, ex_wdata});
      if (acc && ex_t_wen) m_sr_t = ex_t;
      else if (sr_t_wr) m_sr_t = sr_t_wdata;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst_n, ex_valid, ex_t_wen, ex_t, ex_wen;
    logic [3:0] ex_wdst; logic [31:0] ex_wdata;
    logic sr_t_wr, sr_t_wdata, lsu_wen;
    logic [3:0] lsu_wdst; logic [31:0] lsu_wdata;
    logic e_ready, e_rf_wen; logic [3:0] e_rf_wdst; logic [31:0] e_rf_wdata;
    logic [15:0] e_pend; logic e_sr_t;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic fill_table();
    //          rst v tw t w dst data          sw swd lw ldst ldata        | rdy rfw rdst rdata         pend      srt
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[1]  = '{1, 1, 0, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 1, 3, 32'h12345678, 16'h0008, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[4]  = '{1, 1, 0, 0, 1, 1, 32'h11,       0, 0, 1, 7, 32'hAAAA0001,   1, 1, 7, 32'hAAAA0001, 16'h0000, 0};
    vecs[5]  = '{1, 1, 0, 0, 1, 2, 32'h22,       0, 0, 1, 7, 32'hAAAA0002,   1, 1, 7, 32'hAAAA0002, 16'h0002, 0};
    vecs[6]  = '{1, 1, 0, 0, 1, 4, 32'h44,       0, 0, 1, 7, 32'hAAAA0003,   0, 1, 7, 32'hAAAA0003, 16'h0006, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 1, 1, 32'h11,       16'h0006, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 1, 2, 32'h22,       16'h0004, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[10] = '{1, 1, 1, 1, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 1};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
    vecs[13] = '{1, 1, 0, 0, 1, 8, 32'h88,       0, 0, 1, 9, 32'h99,         1, 1, 9, 32'h99,       16'h0000, 0};
    vecs[14] = '{1, 1, 0, 0, 1, 9, 32'h89,       0, 0, 1, 9, 32'h9A,         1, 1, 9, 32'h9A,       16'h0100, 0};
    vecs[15] = '{1, 1, 1, 1, 0, 0, 32'h0,        0, 0, 1, 9, 32'h9B,         0, 1, 9, 32'h9B,       16'h0300, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 1, 8, 32'h88,       16'h0300, 0};
    vecs[17] = '{1, 1, 1, 1, 0, 0, 32'h0,        0, 0, 1, 9, 32'h9C,         1, 1, 9, 32'h9C,       16'h0200, 0};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 1, 9, 32'h89,       16'h0200, 1};
    vecs[19] = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 1};
    vecs[20] = '{1, 1, 0, 0, 1, 10, 32'hA0,      0, 0, 1, 9, 32'h9D,         1, 1, 9, 32'h9D,       16'h0000, 1};
    vecs[21] = '{1, 1, 0, 0, 1, 11, 32'hB0,      0, 0, 1, 9, 32'h9E,         1, 1, 9, 32'h9E,       16'h0400, 1};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        16'h0C00, 1};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 5, 32'h55,         1, 1, 5, 32'h55,       16'h0000, 0};
    vecs[24] = '{1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,        16'h0000, 0};
  endtask

  task automatic apply_vec(input vec_t v);
    rst_n = v.rst_n; ex_valid = v.ex_valid; ex_t_wen = v.ex_t_wen; ex_t = v.ex_t;
    ex_wen = v.ex_wen; ex_wdst = v.ex_wdst; ex_wdata = v.ex_wdata;
    sr_t_wr = v.sr_t_wr; sr_t_wdata = v.sr_t_wdata;
    lsu_wen = v.lsu_wen; lsu_wdst = v.lsu_wdst; lsu_wdata = v.lsu_wdata;
    #1;
    check("vec_ex_ready", 32'(ex_ready), 32'(v.e_ready));
    check("vec_rf_wen", 32'(rf_wen), 32'(v.e_rf_wen));
    check("vec_rf_wdst", 32'(rf_wdst), 32'(v.e_rf_wdst));
    check("vec_rf_wdata", rf_wdata, v.e_rf_wdata);
    check("vec_pend_mask", 32'(pend_mask), 32'(v.e_pend));
    check("vec_sr_t", 32'(sr_t), 32'(v.e_sr_t));
    tick();
  endtask

  // ---------------- random phase against the model ----------------
  task automatic check_model();
    logic [15:0] e_pend;
    logic        e_rfw;
    logic [3:0]  e_rdst;
    logic [31:0] e_rdat;
    e_pend = '0;
    foreach (exp_q[i]) e_pend[exp_q[i][35:32]] = 1'b1;
    e_rfw = 1'b0; e_rdst = '0; e_rdat = '0;
    if (lsu_wen) begin
      e_rfw = 1'b1; e_rdst = lsu_wdst; e_rdat = lsu_wdata;
    end else if (rst_n && exp_q.size() > 0) begin
      e_rfw = 1'b1; e_rdst = exp_q[0][35:32]; e_rdat = exp_q[0][31:0];
    end
    check("rnd_ex_ready", 32'(ex_ready), 32'(exp_q.size() < DEPTH));
    check("rnd_rf_wen", 32'(rf_wen), 32'(e_rfw));
    check("rnd_rf_wdst", 32'(rf_wdst), 32'(e_rdst));
    check("rnd_rf_wdata", rf_wdata, e_rdat);
    check("rnd_pend_mask", 32'(pend_mask), 32'(e_pend));
    check("rnd_sr_t", 32'(sr_t), 32'(m_sr_t));
`ifdef WB_BYPASS_EN
    begin
      logic        e_hit;
      logic [31:0] e_bd;
      e_hit = 1'b0; e_bd = '0;
      foreach (exp_q[i]) if (exp_q[i][35:32] == byp_rsel) begin e_hit = 1'b1; e_bd = exp_q[i][31:0]; end
      check("rnd_byp_hit", 32'(byp_hit), 32'(e_hit));
      check("rnd_byp_data", byp_data, e_bd);
    end
`endif
  endtask

  task automatic random_cycle();
    logic [15:0] busy;
    logic [3:0]  ld;
    busy = '0;
    foreach (exp_q[i]) busy[exp_q[i][35:32]] = 1'b1;
    rst_n      = ($urandom_range(0, 49) != 0);
    ex_valid   = ($urandom_range(0, 99) < 60);
    ex_t_wen   = ($urandom_range(0, 2) == 0);
    ex_t       = 1'($urandom);
    ex_wen     = ($urandom_range(0, 3) != 0);
    ex_wdst    = 4'($urandom);
    ex_wdata   = $urandom;
    sr_t_wr    = ($urandom_range(0, 3) == 0);
    sr_t_wdata = 1'($urandom);
    lsu_wen    = ($urandom_range(0, 99) < 30);
    // Loads never target a register still pending in the queue.
    ld = 4'($urandom);
    while (busy[ld]) ld = ld + 4'd1;
    lsu_wdst   = ld;
    lsu_wdata  = $urandom;
`ifdef WB_BYPASS_EN
    byp_rsel   = ($urandom_range(0, 1) == 0 && exp_q.size() > 0) ? exp_q[$][35:32] : 4'($urandom);
`endif
    #1;
    check_model();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_edge();
    @(posedge clk);
    #1;

    fill_table();
    for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

`ifdef WB_BYPASS_EN
    // Two writes to R5 held in the queue by LSU traffic; youngest must win.
    set_idle();
    ex_valid = 1'b1; ex_wen = 1'b1; ex_wdst = 4'd5; ex_wdata = 32'hA;
    lsu_wen = 1'b1; lsu_wdst = 4'd1; lsu_wdata = 32'h0;
    tick();
    ex_wdata = 32'hB;
    tick();
    ex_valid = 1'b0; ex_wen = 1'b0;
    byp_rsel = 4'd5;
    #1;
    check("byp_hit_r5", 32'(byp_hit), 32'd1);
    check("byp_data_r5", byp_data, 32'hB);
    byp_rsel = 4'd6;
    #1;
    check("byp_hit_r6", 32'(byp_hit), 32'd0);
    lsu_wen = 1'b0;
    tick();
    tick();
    tick();
`endif

    set_idle();
    for (int i = 0; i < 400; i++) random_cycle();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
